dff_serial_deserializer: RTL and testbench



---
 rtl/dff_serial_deserializer_if.sv | 32 +++
 rtl/dff_serial_deserializer.sv | 139 +++++++++++++
 tb/tb_dff_serial_deserializer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dff_serial_deserializer_if.sv
// Output-side bus of the serial deserializer: one-entry word register with a
// valid/ready handshake plus an overrun pulse.
//   master : deserializer side (drives out_data/out_valid/overrun[/parity_err])
//   slave  : consumer side (drives out_ready)
// Optional: DESER_PARITY_EN adds parity_err, which qualifies out_data.
interface dff_serial_deserializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             overrun;
`ifdef DESER_PARITY_EN
   logic             parity_err;
`endif

   modport master (
      output out_data, out_valid, overrun,
`ifdef DESER_PARITY_EN
      output parity_err,
`endif
      input  out_ready
   );

   modport slave (
      input  out_data, out_valid, overrun,
`ifdef DESER_PARITY_EN
      input  parity_err,
`endif
      output out_ready
   );
endinterface

// File: rtl/dff_serial_deserializer.sv
// Serial-to-parallel deserializer fed by a single-bit DFF stage.
// Samples d on rising edges where the active-low strobe en is 0, assembles
// WIDTH-bit words (MSB_FIRST selects bit order) and hands each completed word
// to a one-entry output register with a valid/ready handshake. A word that
// completes while the register is full and not draining is dropped and
// flagged by a one-cycle overrun pulse.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   d     - serial bit
//   en    - active-low bit strobe (1 = hold)
//   bus   - dff_serial_deserializer_if.master (out_data, out_valid,
//           out_ready, overrun[, parity_err])
// Optional feature macro: DESER_PARITY_EN -- each frame carries one trailing
// even-parity bit; the word is handed off on the parity edge and parity_err
// reports the check result alongside out_data.
module dff_serial_deserializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   input  logic en,
   dff_serial_deserializer_if.master bus
);
   localparam int CW = $clog2(WIDTH + 2);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_shift;
   logic [CW-1:0]    cnt;
   logic             strobe;
   logic             last_bit;
   logic             done;
   logic [WIDTH-1:0] word;

   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             overrun_q;
   logic             drain;

   assign strobe   = ~en;
   assign last_bit = strobe && (cnt == CW'(WIDTH - 1));
   assign drain    = valid_q && bus.out_ready;

   // MSB-first shifts left so the first bit ends in sr[WIDTH-1];
   // LSB-first shifts right so the first bit ends in sr[0].
   always_comb begin
      sr_shift = sr;
      if (MSB_FIRST) sr_shift = {sr[WIDTH-2:0], d};
      else           sr_shift = {d, sr[WIDTH-1:1]};
   end

`ifdef DESER_PARITY_EN
   typedef enum logic {COLLECT, PARITY} state_t;
   state_t state;
   logic   perr_q;
   logic   perr;

   // Data is already complete in sr when the parity bit arrives.
   assign done = strobe && (state == PARITY);
   assign word = sr;
   assign perr = (^sr) ^ d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= COLLECT;
         sr    <= '0;
         cnt   <= '0;
      end else if (strobe) begin
         case (state)
            COLLECT: begin
               sr <= sr_shift;
               if (last_bit) begin
                  cnt   <= '0;
                  state <= PARITY;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            PARITY:  state <= COLLECT;
            default: state <= COLLECT;
         endcase
      end
   end
`else
   // Word completes on the WIDTH-th bit; hand off the post-shift value.
   assign done = last_bit;
   assign word = sr_shift;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (strobe) begin
         sr  <= sr_shift;
         cnt <= last_bit ? '0 : cnt + CW'(1);
      end
   end
`endif

   // Output register: a completing word loads if the slot is empty or is
   // draining on this same edge; otherwise it is dropped and overrun pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
`ifdef DESER_PARITY_EN
         perr_q    <= 1'b0;
`endif
      end else begin
         overrun_q <= 1'b0;
         if (done) begin
            if (!valid_q || drain) begin
               data_q  <= word;
               valid_q <= 1'b1;
`ifdef DESER_PARITY_EN
               perr_q  <= perr;
`endif
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (drain) begin
            valid_q <= 1'b0;
`ifdef DESER_PARITY_EN
            perr_q  <= 1'b0;
`endif
         end
      end
   end

   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_q;
   assign bus.overrun   = overrun_q;
`ifdef DESER_PARITY_EN
   assign bus.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_dff_serial_deserializer.sv
// Directed bench for dff_serial_deserializer. Two instances share the serial
// stream: dut_m (MSB_FIRST=1) and dut_l (MSB_FIRST=0), so each frame checks
// both bit orders. Inputs change at the falling edge; outputs are sampled 1
// time unit after the rising edge.
module tb_dff_serial_deserializer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic d   = 1'b0;
   logic en  = 1'b1;
   logic ready = 1'b0;
   int   passed = 0;
   int   total  = 0;

   dff_serial_deserializer_if #(.WIDTH(8)) if_m ();
   dff_serial_deserializer_if #(.WIDTH(8)) if_l ();
   assign if_m.out_ready = ready;
   assign if_l.out_ready = ready;

   dff_serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .d(d), .en(en), .bus(if_m));
   dff_serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .d(d), .en(en), .bus(if_l));

   always #5 clk = ~clk;

   task automatic put_bit(input logic b);
      @(negedge clk);
      d  = b;
      en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Sends v[7] first. With parity enabled, pbit follows the data bits.
   // set_rdy raises out_ready just before the completing edge.
   task automatic send_frame(input logic [7:0] v, input logic pbit, input logic set_rdy);
      for (int i = 7; i >= 0; i--) begin
`ifdef DESER_PARITY_EN
         put_bit(v[i]);
`else
         if (i == 0) begin
            @(negedge clk);
            d = v[0];
            en = 1'b0;
            if (set_rdy) ready = 1'b1;
            @(posedge clk);
            #1;
         end else put_bit(v[i]);
`endif
      end
`ifdef DESER_PARITY_EN
      @(negedge clk);
      d = pbit;
      en = 1'b0;
      if (set_rdy) ready = 1'b1;
      @(posedge clk);
      #1;
`else
      if (pbit) begin end
`endif
      en = 1'b1;
   endtask

   task automatic test_reset;
      #12;
      total++; if (if_m.out_valid !== 1'b0) $display("FAIL reset_valid_m got %b want 0", if_m.out_valid); else passed++;
      total++; if (if_m.out_data !== 8'h00) $display("FAIL reset_data_m got %h want 00", if_m.out_data); else passed++;
      total++; if (if_m.overrun !== 1'b0) $display("FAIL reset_overrun_m got %b want 0", if_m.overrun); else passed++;
      total++; if (if_l.out_valid !== 1'b0) $display("FAIL reset_valid_l got %b want 0", if_l.out_valid); else passed++;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (if_m.out_valid !== 1'b0) $display("FAIL idle_valid_m got %b want 0", if_m.out_valid); else passed++;
   endtask

   task automatic test_basic;
      ready = 1'b1;
      send_frame(8'hA5, 1'b0, 1'b0);
      total++; if (if_m.out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", if_m.out_valid); else passed++;
      total++; if (if_m.out_data !== 8'hA5) $display("FAIL basic_data_m got %h want a5", if_m.out_data); else passed++;
      total++; if (if_l.out_data !== 8'hA5) $display("FAIL basic_data_l got %h want a5", if_l.out_data); else passed++;
      total++; if (if_m.overrun !== 1'b0) $display("FAIL basic_overrun got %b want 0", if_m.overrun); else passed++;
      @(posedge clk); #1;
      total++; if (if_m.out_valid !== 1'b0) $display("FAIL basic_drain got %b want 0", if_m.out_valid); else passed++;
      total++; if (if_m.out_data !== 8'hA5) $display("FAIL basic_data_kept got %h want a5", if_m.out_data); else passed++;
   endtask

   task automatic test_gaps_lsb;
      ready = 1'b1;
      put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
      en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (if_l.out_valid !== 1'b0) $display("FAIL gap_no_early_valid got %b want 0", if_l.out_valid); else passed++;
      put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
`ifdef DESER_PARITY_EN
      put_bit(1'b1); put_bit(1'b0);
`else
      put_bit(1'b1);
`endif
      en = 1'b1;
      total++; if (if_l.out_valid !== 1'b1) $display("FAIL gap_valid_l got %b want 1", if_l.out_valid); else passed++;
      total++; if (if_l.out_data !== 8'hA5) $display("FAIL gap_data_l got %h want a5", if_l.out_data); else passed++;
      total++; if (if_m.out_data !== 8'hA5) $display("FAIL gap_data_m got %h want a5", if_m.out_data); else passed++;
      send_frame(8'hC0, 1'b0, 1'b0);
      total++; if (if_l.out_data !== 8'h03) $display("FAIL lsb_data_l got %h want 03", if_l.out_data); else passed++;
      total++; if (if_m.out_data !== 8'hC0) $display("FAIL lsb_data_m got %h want c0", if_m.out_data); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_overrun;
      ready = 1'b0;
      send_frame(8'h3C, 1'b0, 1'b0);
      total++; if (if_m.overrun !== 1'b0) $display("FAIL ovr_first_no_pulse got %b want 0", if_m.overrun); else passed++;
      send_frame(8'hF0, 1'b0, 1'b0);
      total++; if (if_m.overrun !== 1'b1) $display("FAIL ovr_pulse_m got %b want 1", if_m.overrun); else passed++;
      total++; if (if_l.overrun !== 1'b1) $display("FAIL ovr_pulse_l got %b want 1", if_l.overrun); else passed++;
      total++; if (if_m.out_data !== 8'h3C) $display("FAIL ovr_held_m got %h want 3c", if_m.out_data); else passed++;
      total++; if (if_l.out_data !== 8'h3C) $display("FAIL ovr_held_l got %h want 3c", if_l.out_data); else passed++;
      @(posedge clk); #1;
      total++; if (if_m.overrun !== 1'b0) $display("FAIL ovr_one_cycle got %b want 0", if_m.overrun); else passed++;
      total++; if (if_m.out_valid !== 1'b1) $display("FAIL ovr_still_valid got %b want 1", if_m.out_valid); else passed++;
      ready = 1'b1;
      @(posedge clk); #1;
      total++; if (if_m.out_valid !== 1'b0) $display("FAIL ovr_drain got %b want 0", if_m.out_valid); else passed++;
   endtask

   task automatic test_simul_drain;
      ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0);
      total++; if (if_m.out_data !== 8'h11) $display("FAIL sim_pending got %h want 11", if_m.out_data); else passed++;
      send_frame(8'h22, 1'b0, 1'b1);
      total++; if (if_m.out_valid !== 1'b1) $display("FAIL sim_valid got %b want 1", if_m.out_valid); else passed++;
      total++; if (if_m.out_data !== 8'h22) $display("FAIL sim_data_m got %h want 22", if_m.out_data); else passed++;
      total++; if (if_l.out_data !== 8'h44) $display("FAIL sim_data_l got %h want 44", if_l.out_data); else passed++;
      total++; if (if_m.overrun !== 1'b0) $display("FAIL sim_overrun got %b want 0", if_m.overrun); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      ready = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b0);
      put_bit(1'b1); put_bit(1'b1); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
      #3;
      rst = 1'b0;
      #1;
      total++; if (if_m.out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", if_m.out_valid); else passed++;
      total++; if (if_m.out_data !== 8'h00) $display("FAIL rmid_data got %h want 00", if_m.out_data); else passed++;
      total++; if (if_l.out_data !== 8'h00) $display("FAIL rmid_data_l got %h want 00", if_l.out_data); else passed++;
      en = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      ready = 1'b1;
      send_frame(8'h5A, 1'b0, 1'b0);
      total++; if (if_m.out_valid !== 1'b1) $display("FAIL rmid_new_valid got %b want 1", if_m.out_valid); else passed++;
      total++; if (if_m.out_data !== 8'h5A) $display("FAIL rmid_new_data_m got %h want 5a", if_m.out_data); else passed++;
      total++; if (if_l.out_data !== 8'h5A) $display("FAIL rmid_new_data_l got %h want 5a", if_l.out_data); else passed++;
      @(posedge clk); #1;
   endtask

`ifdef DESER_PARITY_EN
   task automatic test_parity;
      ready = 1'b1;
      send_frame(8'hA5, 1'b0, 1'b0);
      total++; if (if_m.out_valid !== 1'b1) $display("FAIL par_valid got %b want 1", if_m.out_valid); else passed++;
      total++; if (if_m.parity_err !== 1'b0) $display("FAIL par_ok got %b want 0", if_m.parity_err); else passed++;
      @(posedge clk); #1;
      send_frame(8'hA5, 1'b1, 1'b0);
      total++; if (if_m.out_data !== 8'hA5) $display("FAIL par_err_data got %h want a5", if_m.out_data); else passed++;
      total++; if (if_m.parity_err !== 1'b1) $display("FAIL par_err got %b want 1", if_m.parity_err); else passed++;
      @(posedge clk); #1;
      total++; if (if_m.parity_err !== 1'b0) $display("FAIL par_err_clear got %b want 0", if_m.parity_err); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_gaps_lsb();
      test_overrun();
      test_simul_drain();
      test_reset_mid();
`ifdef DESER_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
